dp_pipe_stage: RTL



---
 rtl/dp_pipe_pkg.sv | 25 ++
 rtl/dp_sat_counter.sv | 36 +++
 rtl/dp_pipe_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dp_pipe_pkg.sv
// Shared types for the elastic datapath pipeline stage: buffer state encoding
// and occupancy width.
package dp_pipe_pkg;

    localparam int DP_PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } dp_pipe_state_t;

    // The state encoding doubles as the number of entries held.
    function automatic logic [DP_PIPE_OCC_W-1:0] occ_of(input dp_pipe_state_t st);
        logic [DP_PIPE_OCC_W-1:0] occ_v;
        case (st)
            ST_EMPTY: occ_v = 2'd0;
            ST_ONE:   occ_v = 2'd1;
            ST_TWO:   occ_v = 2'd2;
            default:  occ_v = 2'd0;
        endcase
        return occ_v;
    endfunction

endpackage

// File: rtl/dp_sat_counter.sv
// Saturating up-counter with synchronous clear, for stall/perf statistics.
// Present only when DP_PIPE_STALL_CNT_EN is defined.
`ifdef DP_PIPE_STALL_CNT_EN
module dp_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/dp_pipe_stage.sv
// Elastic 2-entry (main + skid) pipeline register with valid/ready handshake
// and flush. Define DP_PIPE_STALL_CNT_EN to add the stall_cnt output.
module dp_pipe_stage
    import dp_pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     FLUSH,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [DP_PIPE_OCC_W-1:0] occ
`ifdef DP_PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    if ((DATA_W < 1) || (DATA_W > 1024) || (CNT_W < 1)) begin : g_bad_param
        $error("dp_pipe_stage: illegal DATA_W or CNT_W");
    end

    dp_pipe_state_t    state_q;
    dp_pipe_state_t    state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_xfer_s;
    logic              out_xfer_s;

    // Ready comes only from registered state plus Reset/FLUSH, never from out_ready.
    assign in_ready   = (state_q != ST_TWO) & ~Reset & ~FLUSH;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign occ        = occ_of(state_q);
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Next-state and buffer update; FLUSH empties the stage ahead of any transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_d = in_data;
                    end else if (in_xfer_s) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (out_xfer_s) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // The skid entry is older than anything that can arrive, so it moves up.
                    if (out_xfer_s) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef DP_PIPE_STALL_CNT_EN
    logic stall_inc_s;

    assign stall_inc_s = out_valid & ~out_ready & ~FLUSH;

    dp_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (CLK),
        .clr (Reset),
        .inc (stall_inc_s),
        .cnt (stall_cnt)
    );
`endif

endmodule
